id_stage_fwd: RTL and testbench

- Parametrised successor to the combinational decode stage: decode, operand forwarding from NUM_FWD younger pipeline stages, and load-use hazard detection.
- Also contains the ID/EX pipeline register, with stall, flush and bubble insertion.
- Sits between the IF/ID register and the EX stage; reads the regfile combinationally and raises a stall request to the pipeline controller.

---
 rtl/id_stage_fwd_pkg.sv | 141 ++++++++++++++
 rtl/id_stage_fwd_fwd_mux.sv | 29 ++
 rtl/id_stage_fwd.sv | 154 +++++++++++++++
 tb/tb_id_stage_fwd.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_fwd_pkg.sv
// Shared decode constants and the decode function for the ID stage.
package id_stage_fwd_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0;

  localparam logic [7:0] ALU_NOP = 8'h00;
  localparam logic [7:0] ALU_OR  = 8'h25;
  localparam logic [7:0] ALU_SLL = 8'h7C;
  localparam logic [7:0] ALU_SRL = 8'h02;
  localparam logic [7:0] ALU_SRA = 8'h03;
  localparam logic [7:0] ALU_LW  = 8'hE3;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_LOAD  = 3'b111;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_ZE, IMM_SE, IMM_HI, IMM_SA
  } imm_t;

  typedef struct packed {
    logic [7:0] aluop;
    logic [2:0] alusel;
    logic       rd1;
    logic       rd2;
    imm_t       imm;
    logic [4:0] wd;
    logic       load;
    logic       legal;
  } dec_t;

  localparam dec_t DEC_NOP = '{
    aluop: ALU_NOP, alusel: SEL_NOP, rd1: 1'b0,
    rd2: 1'b0, imm: IMM_NONE, wd: 5'd0,
    load: 1'b0, legal: 1'b0
  };

  // Shift ops share codes between variable and sa forms.
  function automatic logic [7:0] shift_op(
    input logic [1:0] f
  );
    logic [7:0] r;
    r = ALU_SLL;
    if (f == 2'b10) r = ALU_SRL;
    if (f == 2'b11) r = ALU_SRA;
    return r;
  endfunction

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    logic [5:0] op;
    logic [5:0] fn;
    logic sp;
    logic sa0;
    logic rs0;
    op  = inst[31:26];
    fn  = inst[5:0];
    sp  = (op == OP_SPECIAL);
    sa0 = (inst[10:6] == 5'd0);
    rs0 = (inst[25:21] == 5'd0);
    d   = DEC_NOP;
    unique case (1'b1)
      sp && sa0 &&
      (fn inside {F_AND, F_OR, F_XOR, F_NOR}): begin
        d.aluop  = {2'b00, fn};
        d.alusel = SEL_LOGIC;
        d.rd1    = 1'b1;
        d.rd2    = 1'b1;
        d.wd     = inst[15:11];
        d.legal  = 1'b1;
      end
      sp && sa0 &&
      (fn inside {F_SLLV, F_SRLV, F_SRAV}): begin
        d.aluop  = shift_op(fn[1:0]);
        d.alusel = SEL_SHIFT;
        d.rd1    = 1'b1;
        d.rd2    = 1'b1;
        d.wd     = inst[15:11];
        d.legal  = 1'b1;
      end
      sp && rs0 &&
      (fn inside {F_SLL, F_SRL, F_SRA}): begin
        d.aluop  = shift_op(fn[1:0]);
        d.alusel = SEL_SHIFT;
        d.rd2    = 1'b1;
        d.imm    = IMM_SA;
        d.wd     = inst[15:11];
        d.legal  = 1'b1;
      end
      op inside {OP_ANDI, OP_ORI, OP_XORI}: begin
        d.aluop  = {6'b001001, op[1:0]};
        d.alusel = SEL_LOGIC;
        d.rd1    = 1'b1;
        d.imm    = IMM_ZE;
        d.wd     = inst[20:16];
        d.legal  = 1'b1;
      end
      op == OP_LUI: begin
        d.aluop  = ALU_OR;
        d.alusel = SEL_LOGIC;
        d.rd1    = 1'b1;
        d.imm    = IMM_HI;
        d.wd     = inst[20:16];
        d.legal  = 1'b1;
      end
      op == OP_LW: begin
        d.aluop  = ALU_LW;
        d.alusel = SEL_LOAD;
        d.rd1    = 1'b1;
        d.imm    = IMM_SE;
        d.wd     = inst[20:16];
        d.load   = 1'b1;
        d.legal  = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_stage_fwd_fwd_mux.sv
// One operand: immediate, zero register, priority forward, regfile.
module id_fwd_mux #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      re_i,
  input  logic [REG_AW-1:0]         addr_i,
  input  logic [DATA_W-1:0]         rf_i,
  input  logic [DATA_W-1:0]         imm_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  output logic [DATA_W-1:0]         data_o
);

  // Walk oldest to youngest so the lowest index wins.
  always_comb begin
    data_o = rf_i;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_wreg_i[k] &&
          fwd_wd_i[k*REG_AW +: REG_AW] == addr_i)
        data_o = fwd_wdata_i[k*DATA_W +: DATA_W];
    end
    if (addr_i == '0) data_o = '0;
    if (!re_i) data_o = imm_i;
  end

endmodule

// File: rtl/id_stage_fwd.sv
// Decode with operand forwarding, load-use detection and ID/EX register.
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int PC_W    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic [PC_W-1:0]           pc_i,
  input  logic [31:0]               inst_i,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic                      fwd_load_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [REG_AW-1:0]         reg1_addr_o,
  output logic [REG_AW-1:0]         reg2_addr_o,
  output logic                      stallreq_o,
  output logic                      ex_valid_o,
  output logic [PC_W-1:0]           ex_pc_o,
  output logic [7:0]                ex_aluop_o,
  output logic [2:0]                ex_alusel_o,
  output logic [DATA_W-1:0]         ex_reg1_o,
  output logic [DATA_W-1:0]         ex_reg2_o,
  output logic [REG_AW-1:0]         ex_wd_o,
  output logic                      ex_wreg_o,
  output logic                      ex_load_o,
  output logic                      ex_illegal_o
);

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [7:0]        aluop;
    logic [2:0]        alusel;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic              load;
    logic              illegal;
  } id_ex_t;

  dec_t              dec;
  id_ex_t            dec_ex;
  id_ex_t            ex_d;
  id_ex_t            ex_q;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_v;
  logic [DATA_W-1:0] imm1;
  logic [DATA_W-1:0] imm2;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [REG_AW-1:0] wd0;
  logic              hit;

  assign dec   = decode(inst_i);
  assign imm16 = inst_i[15:0];

  assign reg1_read_o = dec.rd1;
  assign reg2_read_o = dec.rd2;
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);

  always_comb begin
    imm_v = '0;
    unique case (dec.imm)
      IMM_ZE: imm_v = DATA_W'(imm16);
      IMM_SE: imm_v = {{(DATA_W-16){imm16[15]}}, imm16};
      IMM_HI: imm_v = DATA_W'({imm16, 16'h0});
      IMM_SA: imm_v = DATA_W'(inst_i[10:6]);
      default: imm_v = '0;
    endcase
  end

  // Shift amount feeds operand 1; every other immediate feeds operand 2.
  assign imm1 = (dec.imm == IMM_SA) ? imm_v : '0;
  assign imm2 = (dec.imm == IMM_SA) ? '0 : imm_v;

  id_fwd_mux #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)
  ) u_mux1 (
    .re_i(dec.rd1), .addr_i(reg1_addr_o),
    .rf_i(reg1_data_i), .imm_i(imm1),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i), .data_o(op1)
  );

  id_fwd_mux #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)
  ) u_mux2 (
    .re_i(dec.rd2), .addr_i(reg2_addr_o),
    .rf_i(reg2_data_i), .imm_i(imm2),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i), .data_o(op2)
  );

  assign wd0 = fwd_wd_i[REG_AW-1:0];
  assign hit = (dec.rd1 && reg1_addr_o == wd0) ||
               (dec.rd2 && reg2_addr_o == wd0);
  assign stallreq_o = valid_i && fwd_load_i &&
                      fwd_wreg_i[0] && (wd0 != '0) && hit;

  always_comb begin
    dec_ex = '0;
    if (valid_i) begin
      dec_ex.valid   = 1'b1;
      dec_ex.pc      = pc_i;
      dec_ex.aluop   = dec.aluop;
      dec_ex.alusel  = dec.alusel;
      dec_ex.reg1    = op1;
      dec_ex.reg2    = op2;
      dec_ex.wd      = REG_AW'(dec.wd);
      dec_ex.wreg    = (dec.legal && dec.wd != 5'd0)
                       ? WriteEnable : 1'b0;
      dec_ex.load    = dec.load;
      dec_ex.illegal = !dec.legal;
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (flush_i)         ex_d = '0;
    else if (stall_i)    ex_d = ex_q;
    else if (stallreq_o) ex_d = '0;
    else                 ex_d = dec_ex;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) ex_q <= '0;
    else                  ex_q <= ex_d;
  end

  assign ex_valid_o   = ex_q.valid;
  assign ex_pc_o      = ex_q.pc;
  assign ex_aluop_o   = ex_q.aluop;
  assign ex_alusel_o  = ex_q.alusel;
  assign ex_reg1_o    = ex_q.reg1;
  assign ex_reg2_o    = ex_q.reg2;
  assign ex_wd_o      = ex_q.wd;
  assign ex_wreg_o    = ex_q.wreg;
  assign ex_load_o    = ex_q.load;
  assign ex_illegal_o = ex_q.illegal;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Scoreboard bench for id_stage_fwd: directed vectors, queued expectations.
module tb_id_stage_fwd;

  typedef struct packed {
    logic        sr;
    logic        rd1;
    logic        rd2;
    logic        v;
    logic [31:0] pc;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wr;
    logic        ld;
    logic        il;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid, fload;
  logic [31:0] pc, inst, rf1, rf2;
  logic [1:0]  fwreg;
  logic [9:0]  fwd;
  logic [63:0] fwdata;
  logic [2:0]  fwreg3;
  logic [14:0] fwd3;
  logic [95:0] fwdata3;

  logic        rd1_o, rd2_o, sr_o;
  logic [4:0]  a1_o, a2_o;
  logic        v_o, wr_o, ld_o, il_o;
  logic [31:0] pc_o, r1_o, r2_o;
  logic [7:0]  op_o;
  logic [2:0]  sel_o;
  logic [4:0]  wd_o;

  logic        d3_rd1, d3_rd2, d3_sr;
  logic [4:0]  d3_a1, d3_a2;
  logic        d3_v, d3_wr, d3_ld, d3_il;
  logic [31:0] d3_pc, d3_r1, d3_r2;
  logic [7:0]  d3_op;
  logic [2:0]  d3_sel;
  logic [4:0]  d3_wd;

  exp_t  sbq[$];
  string nq[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  id_stage_fwd dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .valid_i(valid), .pc_i(pc), .inst_i(inst),
    .reg1_data_i(rf1), .reg2_data_i(rf2),
    .fwd_wreg_i(fwreg), .fwd_wd_i(fwd),
    .fwd_wdata_i(fwdata), .fwd_load_i(fload),
    .reg1_read_o(rd1_o), .reg2_read_o(rd2_o),
    .reg1_addr_o(a1_o), .reg2_addr_o(a2_o),
    .stallreq_o(sr_o), .ex_valid_o(v_o), .ex_pc_o(pc_o),
    .ex_aluop_o(op_o), .ex_alusel_o(sel_o),
    .ex_reg1_o(r1_o), .ex_reg2_o(r2_o), .ex_wd_o(wd_o),
    .ex_wreg_o(wr_o), .ex_load_o(ld_o), .ex_illegal_o(il_o)
  );

  id_stage_fwd #(.NUM_FWD(3)) dut3 (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .valid_i(valid), .pc_i(pc), .inst_i(inst),
    .reg1_data_i(rf1), .reg2_data_i(rf2),
    .fwd_wreg_i(fwreg3), .fwd_wd_i(fwd3),
    .fwd_wdata_i(fwdata3), .fwd_load_i(1'b0),
    .reg1_read_o(d3_rd1), .reg2_read_o(d3_rd2),
    .reg1_addr_o(d3_a1), .reg2_addr_o(d3_a2),
    .stallreq_o(d3_sr), .ex_valid_o(d3_v), .ex_pc_o(d3_pc),
    .ex_aluop_o(d3_op), .ex_alusel_o(d3_sel),
    .ex_reg1_o(d3_r1), .ex_reg2_o(d3_r2), .ex_wd_o(d3_wd),
    .ex_wreg_o(d3_wr), .ex_load_o(d3_ld), .ex_illegal_o(d3_il)
  );

  function automatic exp_t mk(
    input logic sr, input logic rd1, input logic rd2,
    input logic v, input logic [31:0] p,
    input logic [7:0] op, input logic [2:0] sel,
    input logic [31:0] r1, input logic [31:0] r2,
    input logic [4:0] wd, input logic wr,
    input logic ld, input logic il
  );
    exp_t e;
    e = '{sr, rd1, rd2, v, p, op, sel, r1, r2, wd, wr, ld, il};
    return e;
  endfunction

  function automatic exp_t bub(
    input logic sr, input logic rd1, input logic rd2
  );
    return mk(sr, rd1, rd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic cyc(input string n, input exp_t e);
    sbq.push_back(e);
    nq.push_back(n);
    @(negedge clk);
  endtask

  // Monitor: comb outputs sampled at the edge, registers just after.
  initial begin
    exp_t  e;
    exp_t  g;
    string n;
    forever begin
      @(posedge clk);
      g.sr  = sr_o;
      g.rd1 = rd1_o;
      g.rd2 = rd2_o;
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n = nq.pop_front();
        g.v = v_o;   g.pc = pc_o;   g.op = op_o;
        g.sel = sel_o; g.r1 = r1_o; g.r2 = r2_o;
        g.wd = wd_o; g.wr = wr_o;  g.ld = ld_o;
        g.il = il_o;
        checks++;
        if (g != e) begin
          errors++;
          $display({"FAIL %s: got sr=%0d rd=%0d%0d v=%0d pc=%h",
                    " op=%h sel=%0d r1=%h r2=%h wd=%0d wr=%0d",
                    " ld=%0d il=%0d; required sr=%0d rd=%0d%0d",
                    " v=%0d pc=%h op=%h sel=%0d r1=%h r2=%h",
                    " wd=%0d wr=%0d ld=%0d il=%0d"},
                   n, g.sr, g.rd1, g.rd2, g.v, g.pc, g.op,
                   g.sel, g.r1, g.r2, g.wd, g.wr, g.ld, g.il,
                   e.sr, e.rd1, e.rd2, e.v, e.pc, e.op,
                   e.sel, e.r1, e.r2, e.wd, e.wr, e.ld, e.il);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; valid = 1'b1;
    fload = 1'b0; pc = 32'h0; inst = 32'h0;
    rf1 = 32'h0; rf2 = 32'h0;
    fwreg = 2'b00; fwd = '0; fwdata = '0;
    fwreg3 = 3'b100;
    fwd3 = {5'd1, 5'd1, 5'd1};
    fwdata3 = {32'h333, 32'h222, 32'h111};
    @(negedge clk);

    rst = 1'b1; inst = 32'h34011100;
    cyc("reset0", bub(0, 1, 0));
    cyc("reset1", bub(0, 1, 0));
    rst = 1'b0;

    pc = 32'h100;
    cyc("ori", mk(0, 1, 0, 1, 32'h100, 8'h25, 3'd1,
                  32'h0, 32'h1100, 5'd1, 1, 0, 0));

    pc = 32'h104; inst = 32'h00221825;
    fwreg = 2'b11; fwd = {5'd1, 5'd1};
    fwdata = {32'h55, 32'hAA};
    cyc("or_fwd0", mk(0, 1, 1, 1, 32'h104, 8'h25, 3'd1,
                      32'hAA, 32'h0, 5'd3, 1, 0, 0));
    checks++;
    if (d3_r1 !== 32'h333) begin
      errors++;
      $display("FAIL nfwd3_src2: got reg1=%h required %h",
               d3_r1, 32'h333);
    end

    pc = 32'h108; fwreg = 2'b10;
    cyc("or_fwd1", mk(0, 1, 1, 1, 32'h108, 8'h25, 3'd1,
                      32'h55, 32'h0, 5'd3, 1, 0, 0));

    pc = 32'h10C; inst = 32'h00822824;
    fwreg = 2'b01; fwd = {5'd0, 5'd4}; fload = 1'b1;
    cyc("load_use", bub(1, 1, 1));

    pc = 32'h110; inst = 32'h34040001;
    cyc("no_load_use", mk(0, 1, 0, 1, 32'h110, 8'h25, 3'd1,
                          32'h0, 32'h1, 5'd4, 1, 0, 0));

    pc = 32'h114; inst = 32'h00000825; fload = 1'b0;
    fwreg = 2'b01; fwd = {5'd0, 5'd0};
    fwdata = {32'h0, 32'hFFFFFFFF};
    rf1 = 32'h12345678; rf2 = 32'h12345678;
    cyc("fwd_r0", mk(0, 1, 1, 1, 32'h114, 8'h25, 3'd1,
                     32'h0, 32'h0, 5'd1, 1, 0, 0));

    pc = 32'h118; inst = 32'h0; fwreg = 2'b00;
    cyc("nop", mk(0, 0, 1, 1, 32'h118, 8'h7C, 3'd2,
                  32'h0, 32'h0, 5'd0, 0, 0, 0));

    pc = 32'h11C; inst = 32'hFC000000;
    cyc("illegal", mk(0, 0, 0, 1, 32'h11C, 8'h00, 3'd0,
                      32'h0, 32'h0, 5'd0, 0, 0, 1));

    pc = 32'h120; inst = 32'h8C24FFFC;
    rf1 = 32'h1000; rf2 = 32'h0;
    cyc("lw", mk(0, 1, 0, 1, 32'h120, 8'hE3, 3'd7,
                 32'h1000, 32'hFFFFFFFC, 5'd4, 1, 1, 0));

    pc = 32'h124; inst = 32'h00031143; rf2 = 32'hF0;
    fwreg = 2'b01; fwd = {5'd0, 5'd3};
    fwdata = {32'h0, 32'hBEEF};
    cyc("sra_fwd", mk(0, 0, 1, 1, 32'h124, 8'h03, 3'd2,
                      32'h5, 32'hBEEF, 5'd2, 1, 0, 0));

    pc = 32'h128; inst = 32'h3C07ABCD; fwreg = 2'b00;
    cyc("lui", mk(0, 1, 0, 1, 32'h128, 8'h25, 3'd1,
                  32'h0, 32'hABCD0000, 5'd7, 1, 0, 0));

    stall = 1'b1; pc = 32'h12C; inst = 32'h00221825;
    for (int i = 0; i < 3; i++)
      cyc("stall_hold", mk(0, 1, 1, 1, 32'h128, 8'h25, 3'd1,
                           32'h0, 32'hABCD0000, 5'd7, 1, 0, 0));

    flush = 1'b1;
    cyc("flush_stall", bub(0, 1, 1));

    stall = 1'b0; flush = 1'b0;
    pc = 32'h130; inst = 32'h3928FFFF; rf1 = 32'h0F0F0F0F;
    cyc("xori", mk(0, 1, 0, 1, 32'h130, 8'h26, 3'd1,
                   32'h0F0F0F0F, 32'h0000FFFF, 5'd8, 1, 0, 0));

    stall = 1'b1; rst = 1'b1;
    cyc("rst_in_stall", bub(0, 1, 0));

    stall = 1'b0; rst = 1'b0; valid = 1'b0;
    inst = 32'h00221825;
    fwreg = 2'b01; fwd = {5'd0, 5'd1}; fload = 1'b1;
    cyc("invalid", bub(0, 1, 1));

    valid = 1'b1;
    cyc("load_use_rs", bub(1, 1, 1));

    pc = 32'h134; inst = 32'h00E83027; rf1 = 32'h11;
    fwreg = 2'b10; fwd = {5'd8, 5'd0};
    fwdata = {32'h77, 32'h0};
    cyc("nor_fwd1", mk(0, 1, 1, 1, 32'h134, 8'h27, 3'd1,
                       32'h11, 32'h77, 5'd6, 1, 0, 0));

    for (int i = 0; i < 5 && sbq.size() > 0; i++)
      @(negedge clk);
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, required 0",
               sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
